// File: rtl/nec_ir_transmitter.sv
// NEC IR frame transmitter: leader, 32 data bits MSB first, stop mark, gap to a fixed frame period.
// Optional key-held repeat frames are enabled by defining NEC_TX_REPEAT_EN.
module nec_ir_transmitter #(
  parameter int LEAD_MARK   = 160,
  parameter int LEAD_SPACE  = 80,
  parameter int BIT_MARK    = 10,
  parameter int ONE_SPACE   = 30,
  parameter int ZERO_SPACE  = 10,
  parameter int FRAME_TICKS = 1920,
  parameter int REP_SPACE   = 40
) (
  input  logic        nec_clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] word,
  input  logic        hold,
  output logic        ir_out,
  output logic        busy,
  output logic        done,
  output logic [3:0]  dbg_state_o
);

  // Handshake: start is a one-cycle request honoured only while busy=0 (IDLE);
  // busy rises on the following edge and requests during busy=1 are dropped.

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_STOP_MARK,
    S_GAP,
    S_REP_MARK,
    S_REP_SPACE,
    S_REP_STOP
  } state_t;

  // Segment counters are loaded with length-1 and the segment ends at zero.
  localparam logic [7:0]  LM_L       = 8'(LEAD_MARK - 1);
  localparam logic [7:0]  LS_L       = 8'(LEAD_SPACE - 1);
  localparam logic [7:0]  BM_L       = 8'(BIT_MARK - 1);
  localparam logic [7:0]  OS_L       = 8'(ONE_SPACE - 1);
  localparam logic [7:0]  ZS_L       = 8'(ZERO_SPACE - 1);
  localparam logic [7:0]  RS_L       = 8'(REP_SPACE - 1);
  localparam logic [10:0] FRAME_LAST = 11'(FRAME_TICKS - 1);

  state_t      state_q, state_d;
  logic [7:0]  seg_q, seg_d;
  logic [10:0] frame_q, frame_d;
  logic [5:0]  bit_q, bit_d;
  logic [31:0] shreg_q, shreg_d;
  logic        done_q, done_d;
  logic        seg_last;
  logic        frame_last;
  logic        rep_req;

`ifdef NEC_TX_REPEAT_EN
  assign rep_req = hold;
`else
  logic unused_hold;
  assign unused_hold = hold;
  assign rep_req     = 1'b0;
`endif

  assign seg_last   = (seg_q == 8'd0);
  assign frame_last = (frame_q == FRAME_LAST);

  always_ff @(posedge nec_clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      seg_q   <= '0;
      frame_q <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      frame_q <= frame_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    frame_d = frame_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    if (!seg_last) seg_d = seg_q - 8'd1;
    if (state_q != S_IDLE) frame_d = frame_q + 11'd1;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LEAD_MARK;
          shreg_d = word;
          seg_d   = LM_L;
          frame_d = '0;
          bit_d   = '0;
        end
      end
      S_LEAD_MARK: begin
        if (seg_last) begin
          state_d = S_LEAD_SPACE;
          seg_d   = LS_L;
        end
      end
      S_LEAD_SPACE: begin
        if (seg_last) begin
          state_d = S_BIT_MARK;
          seg_d   = BM_L;
        end
      end
      S_BIT_MARK: begin
        if (seg_last) begin
          state_d = S_BIT_SPACE;
          seg_d   = shreg_q[31] ? OS_L : ZS_L;
        end
      end
      S_BIT_SPACE: begin
        if (seg_last) begin
          shreg_d = {shreg_q[30:0], 1'b0};
          bit_d   = bit_q + 6'd1;
          seg_d   = BM_L;
          // The stop mark closes the final space so a receiver sees bit 32 end.
          state_d = (bit_q == 6'd31) ? S_STOP_MARK : S_BIT_MARK;
        end
      end
      S_STOP_MARK: begin
        if (seg_last) state_d = S_GAP;
      end
      S_GAP: begin
        if (frame_last) begin
          frame_d = '0;
          if (rep_req) begin
            state_d = S_REP_MARK;
            seg_d   = LM_L;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_REP_MARK: begin
        if (seg_last) begin
          state_d = S_REP_SPACE;
          seg_d   = RS_L;
        end
      end
      S_REP_SPACE: begin
        if (seg_last) begin
          state_d = S_REP_STOP;
          seg_d   = BM_L;
        end
      end
      S_REP_STOP: begin
        if (seg_last) state_d = S_GAP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ir_out      = ~(state_q inside {S_LEAD_MARK, S_BIT_MARK, S_STOP_MARK,
                                         S_REP_MARK, S_REP_STOP});
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_nec_ir_transmitter.sv
// Directed-plus-random bench for nec_ir_transmitter: waveform model per frame and an
// independent run-length NEC decoder on ir_out for loopback checking.
module tb_nec_ir_transmitter;

  logic        nec_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic        hold    = 1'b0;
  logic [31:0] word    = '0;
  logic        ir_out;
  logic        busy;
  logic        done;
  logic [3:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] dec_q[$];
  logic        exp_wave [0:1919];

  nec_ir_transmitter dut (
    .nec_clk    (nec_clk),
    .reset_n    (reset_n),
    .start      (start),
    .word       (word),
    .hold       (hold),
    .ir_out     (ir_out),
    .busy       (busy),
    .done       (done),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 nec_clk = ~nec_clk;

  // ---------------- loopback decoder (run lengths on ir_out) ----------------
  logic        dec_prev   = 1'b1;
  int          dec_run    = 0;
  bit          dec_active = 1'b0;
  int          dec_nbits  = 0;
  logic [31:0] dec_sh     = '0;

  always @(negedge nec_clk) begin
    if (ir_out === dec_prev) begin
      dec_run = dec_run + 1;
    end else begin
      if (dec_prev === 1'b1) begin
        if (dec_run >= 60) begin
          dec_active = 1'b1;
          dec_nbits  = 0;
        end else if (dec_active && dec_run >= 20 && dec_run <= 35) begin
          dec_sh    = {dec_sh[30:0], 1'b1};
          dec_nbits = dec_nbits + 1;
        end else if (dec_active && dec_run >= 5 && dec_run <= 15) begin
          dec_sh    = {dec_sh[30:0], 1'b0};
          dec_nbits = dec_nbits + 1;
        end else begin
          dec_active = 1'b0;
        end
        if (dec_active && dec_nbits == 32) begin
          dec_q.push_back(dec_sh);
          dec_active = 1'b0;
        end
      end
      dec_prev = ir_out;
      dec_run  = 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick;
    @(posedge nec_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void fill_low(input int pos, input int len);
    for (int i = pos; i < pos + len; i++) exp_wave[i] = 1'b0;
  endfunction

  // Reference line shape of one frame period, built from the NEC segment rules.
  function automatic void build_wave(input logic [31:0] w, input bit rep);
    int pos;
    for (int i = 0; i < 1920; i++) exp_wave[i] = 1'b1;
    fill_low(0, 160);
    pos = rep ? 200 : 240;
    if (!rep) begin
      for (int b = 31; b >= 0; b--) begin
        fill_low(pos, 10);
        pos = pos + 10 + (w[b] ? 30 : 10);
      end
    end
    fill_low(pos, 10);
  endfunction

  task automatic do_reset;
    start   = 1'b0;
    reset_n = 1'b0;
    repeat (3) tick;
    chk("reset ir_out", ir_out, 1);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    reset_n = 1'b1;
    tick;
    exp_q.delete();
    dec_q.delete();
  endtask

  task automatic send(input logic [31:0] w);
    word  = w;
    start = 1'b1;
    tick;
    start = 1'b0;
    word  = $urandom;
    exp_q.push_back(w);
  endtask

  // Samples one full frame period starting at its first leader-mark cycle.
  task automatic run_frame(input logic [31:0] w, input bit rep, input int poke_at,
                           input bit expect_done, input string tag);
    int bad      = 0;
    int first    = -1;
    int busy_low = 0;
    int done_hi  = 0;
    build_wave(w, rep);
    for (int c = 0; c < 1920; c++) begin
      if (c == poke_at) begin
        start = 1'b1;
        word  = $urandom;
      end else begin
        start = 1'b0;
      end
      if (ir_out !== exp_wave[c]) begin
        if (first < 0) first = c;
        bad++;
      end
      if (busy !== 1'b1) busy_low++;
      if (done !== 1'b0) done_hi++;
      tick;
    end
    start = 1'b0;
    chk($sformatf("%s wave mismatches (first cycle %0d)", tag, first), bad, 0);
    chk({tag, " busy low cycles"}, busy_low, 0);
    chk({tag, " early done cycles"}, done_hi, 0);
    if (expect_done) begin
      chk({tag, " done at end"}, done, 1);
      chk({tag, " busy at end"}, busy, 0);
    end else begin
      chk({tag, " no done at end"}, done, 0);
      chk({tag, " busy held"}, busy, 1);
    end
  endtask

  task automatic check_decode(input string tag);
    chk({tag, " decoded count"}, dec_q.size(), 1);
    if (dec_q.size() != 0 && exp_q.size() != 0)
      chk({tag, " decoded word"}, dec_q.pop_front(), exp_q.pop_front());
    dec_q.delete();
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] w;
  logic [31:0] loop_words [4];
  int          target;
  int          done_hi;
  int          busy_hi;

  initial begin
    loop_words[0] = 32'h20DF6A95;
    loop_words[1] = 32'h20DFEA15;
    loop_words[2] = 32'h20DF1AE5;
    loop_words[3] = 32'h20DF9A65;

    do_reset();

    // Basic frame, then done must be a single-cycle pulse.
    send(32'h20DF6A95);
    run_frame(32'h20DF6A95, 1'b0, -1, 1'b1, "t1");
    check_decode("t1");
    tick;
    chk("t1 done one cycle", done, 0);

    // Longest and shortest active frames.
    tick;
    send(32'hFFFFFFFF);
    run_frame(32'hFFFFFFFF, 1'b0, -1, 1'b1, "t2 ones");
    check_decode("t2 ones");
    tick;
    send(32'h00000000);
    run_frame(32'h00000000, 1'b0, -1, 1'b1, "t2 zeros");
    check_decode("t2 zeros");

    // Start while busy is ignored; start in the done cycle is accepted.
    repeat ($urandom_range(1, 4)) tick;
    w = $urandom;
    send(w);
    run_frame(w, 1'b0, 500, 1'b1, "t3 poke");
    check_decode("t3 poke");
    w = $urandom;
    send(w);
    chk("t3 done-cycle start ir_out", ir_out, 0);
    chk("t3 done-cycle start done cleared", done, 0);
    run_frame(w, 1'b0, -1, 1'b1, "t3 back2back");
    check_decode("t3 back2back");

    // Reset during the 12th bit mark.
    tick;
    w = $urandom;
    send(w);
    target = 240;
    for (int b = 31; b >= 21; b--) target = target + 10 + (w[b] ? 30 : 10);
    target = target + 3;
    for (int c = 0; c < target; c++) tick;
    chk("t4 inside bit12 mark", ir_out, 0);
    reset_n = 1'b0;
    tick;
    chk("t4 reset ir_out", ir_out, 1);
    chk("t4 reset busy", busy, 0);
    chk("t4 reset done", done, 0);
    reset_n = 1'b1;
    done_hi = 0;
    busy_hi = 0;
    for (int c = 0; c < 2100; c++) begin
      if (done !== 1'b0) done_hi++;
      if (busy !== 1'b0) busy_hi++;
      tick;
    end
    chk("t4 no done after reset", done_hi, 0);
    chk("t4 idle after reset", busy_hi, 0);
    chk("t4 partial frame not decoded", dec_q.size(), 0);
    dec_q.delete();
    exp_q.delete();
    w = $urandom;
    send(w);
    run_frame(w, 1'b0, -1, 1'b1, "t4 recover");
    check_decode("t4 recover");

    // Loopback words, then a few random ones.
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) tick;
      send(loop_words[i]);
      run_frame(loop_words[i], 1'b0, -1, 1'b1, $sformatf("t5 word%0d", i));
      check_decode($sformatf("t5 word%0d", i));
    end
    for (int i = 0; i < 2; i++) begin
      repeat ($urandom_range(0, 3)) tick;
      w = $urandom;
      send(w);
      run_frame(w, 1'b0, -1, 1'b1, $sformatf("rand%0d", i));
      check_decode($sformatf("rand%0d", i));
    end

`ifdef NEC_TX_REPEAT_EN
    // Hold through two frame ends: data frame, two repeat frames, one done.
    tick;
    hold = 1'b1;
    w = $urandom;
    send(w);
    run_frame(w, 1'b0, -1, 1'b0, "t6 data");
    run_frame(w, 1'b1, -1, 1'b0, "t6 rep1");
    hold = 1'b0;
    run_frame(w, 1'b1, -1, 1'b1, "t6 rep2");
    check_decode("t6");
`else
    // Without repeat support hold has no effect.
    tick;
    hold = 1'b1;
    w = $urandom;
    send(w);
    run_frame(w, 1'b0, -1, 1'b1, "t6 hold ignored");
    hold = 1'b0;
    check_decode("t6 hold ignored");
`endif

    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nec_ir_transmitter.md
Name: nec_ir_transmitter

Overview:
- Encodes a 32-bit word into an NEC IR frame on a single line, for IR-blaster output or loopback into the NEC receiver path.
- Counts all timing in nec_clk ticks (1 tick = 56.25 us, so 9 ms = 160 ticks).
- Output polarity matches a demodulated IR receiver: idle high, low = mark (burst).
- Sends word MSB first, so a shift-left decoder reconstructs the identical word.

Parameters:
- LEAD_MARK, 160, leader burst length in ticks (9 ms).
- LEAD_SPACE, 80, leader space length in ticks (4.5 ms).
- BIT_MARK, 10, per-bit and stop burst length in ticks (562.5 us).
- ONE_SPACE, 30, space after a '1' bit in ticks (1687.5 us).
- ZERO_SPACE, 10, space after a '0' bit in ticks (562.5 us).
- FRAME_TICKS, 1920, frame period in ticks (108 ms), measured from the first leader-mark cycle.
- REP_SPACE, 40, repeat-code space in ticks (2.25 ms); used only with REPEAT_EN.

Ports:
- nec_clk  input  1  tick clock; all logic on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request; sampled only when busy=0.
- word  input  32  data to send; latched on an accepted start.
- hold  input  1  key-held indication; used only with REPEAT_EN, ignored otherwise.
- ir_out  output  1  NEC line; 1 = idle/space, 0 = mark.
- busy  output  1  high from the cycle after an accepted start until frame end.
- done  output  1  one-cycle pulse when a frame, including its gap, completes.

Behaviour:
Reset:
- Reset is synchronous. When reset_n=0 at a clock edge: ir_out=1, busy=0, done=0, state=IDLE, and all counters are cleared.
- This also applies mid-frame. A reset mid-frame produces no done pulse.

Accepting a request:
- start is accepted when state=IDLE and start=1.
- On the next edge: word is latched into the shift register, busy=1, state=LEAD_MARK, ir_out=0.
- start while busy=1 is ignored; nothing is queued.

Segment timing:
- Every segment drives ir_out for exactly its tick count, then moves to the next segment on the following edge. No idle cycles are inserted between segments.

States (ir_out value, duration):
- IDLE (1).
- LEAD_MARK (0, LEAD_MARK).
- LEAD_SPACE (1, LEAD_SPACE).
- BIT_MARK (0, BIT_MARK).
- BIT_SPACE (1, ONE_SPACE if current bit = 1, else ZERO_SPACE).
- STOP_MARK (0, BIT_MARK).
- GAP (1, until the frame counter reaches FRAME_TICKS).

Bit sequencing:
- A 6-bit bit counter steps BIT_MARK -> BIT_SPACE 32 times.
- The current bit is shreg[31]; the register shifts left after each BIT_SPACE.
- After the 32nd BIT_SPACE the FSM goes to STOP_MARK. The stop mark is mandatory so the decoder sees the falling edge that ends bit 32.

Frame counter:
- 11 bits wide; counts from the first LEAD_MARK cycle.
- At count FRAME_TICKS-1 in GAP: on the next edge state=IDLE, busy=0, done=1 for one cycle.
- A worst case all-ones frame is 1530 ticks, so GAP is always at least 390 ticks.
- A new start may be accepted in the same cycle done=1, since state=IDLE then.

Segment counter:
- 8 bits wide; reloaded at each segment entry.
- Segment lengths are non-zero by construction; parameter values of 0 are unsupported.

Optional Feature:
Macro: NEC_TX_REPEAT_EN
- Defined:
  - If hold=1 on the last GAP cycle, the FSM enters REP_MARK instead of IDLE. busy stays 1 and no done pulse is issued.
  - Repeat frame: REP_MARK (0, LEAD_MARK), REP_SPACE (1, REP_SPACE), REP_STOP (0, BIT_MARK), then GAP padded to FRAME_TICKS measured from the REP_MARK start.
  - Repeat frames continue while hold=1 at each frame end. done pulses once, after the final frame.
- Undefined:
  - The hold port exists but is ignored. Every frame ends in IDLE with a done pulse.

Test Plan:
1. Reset, then start with word=32'h20DF6A95:
   - ir_out low for exactly 160 cycles, then high for 80, then 32 marks of 10 cycles each.
   - Spaces decode to 0010_0000_1101_1111_0110_1010_1001_0101, MSB first (30 high = 1, 10 high = 0).
   - Stop mark of 10 cycles; done pulses exactly 1920 cycles after the first low cycle.
2. word=32'hFFFFFFFF and word=32'h00000000:
   - Active frame lengths are 1530 and 890 ticks respectively.
   - busy stays high for 1920 cycles in both cases; ir_out stays high through GAP.
3. Start pulsed again at cycle 500 of a frame: ignored, and the latched word is unchanged.
   - Start asserted in the done cycle: new frame begins on the next edge with ir_out=0.
4. reset_n=0 during the 12th bit mark: next edge gives ir_out=1, busy=0, and no done.
   - A following start sends a complete, correct frame.
5. Loopback: feed ir_out into an NEC decoder clocked by the same nec_clk, with words 20DF6A95, 20DFEA15, 20DF1AE5 and 20DF9A65.
   - Each decoded word equals the transmitted word.
6. (NEC_TX_REPEAT_EN) hold=1 through two frame ends, then released:
   - After the data frame come two repeat frames, each 160 low / 40 high / 10 low with a 1920-cycle period.
   - Exactly one done pulse at the end of the second repeat frame.
